branch_history_tracker: RTL

BRANCH_HISTORY_TRACKER -- requirements
Module: branch_history_tracker

---
 rtl/branch_history_tracker_if.sv | 42 ++++
 rtl/branch_history_tracker.sv | 127 ++++++++++++
 2 files changed

// File: rtl/branch_history_tracker_if.sv
// Bus bundle between fetch/writeback and the branch history tracker.
// Performance counter signals exist only when BHT_PERF_COUNTERS_EN is defined.
interface branch_history_tracker_if #(
   parameter int HIST_BITS = 4
);
   logic                 fetch_branch;
   logic [15:0]          fetch_pc;
   logic                 fetch_predict_taken;
   logic                 wb_branch;
   logic                 wb_taken;
   logic                 flush;
   logic [HIST_BITS-1:0] history;
   logic                 fetch_stall;
   logic                 update_pattern;
   logic [15:0]          resolved_pc;
   logic [HIST_BITS-1:0] resolved_history;
   logic                 wb_take_jump;
   logic                 mispredict;
   logic                 underflow_err;
`ifdef BHT_PERF_COUNTERS_EN
   logic [15:0]          branch_count;
   logic [15:0]          mispredict_count;
`endif

   modport master (
`ifdef BHT_PERF_COUNTERS_EN
      input  branch_count, mispredict_count,
`endif
      output fetch_branch, fetch_pc, fetch_predict_taken, wb_branch, wb_taken, flush,
      input  history, fetch_stall, update_pattern, resolved_pc, resolved_history,
      input  wb_take_jump, mispredict, underflow_err
   );

   modport slave (
`ifdef BHT_PERF_COUNTERS_EN
      output branch_count, mispredict_count,
`endif
      input  fetch_branch, fetch_pc, fetch_predict_taken, wb_branch, wb_taken, flush,
      output history, fetch_stall, update_pattern, resolved_pc, resolved_history,
      output wb_take_jump, mispredict, underflow_err
   );
endinterface

// File: rtl/branch_history_tracker.sv
// Speculative global-history tracker with an in-flight branch FIFO and mispredict recovery.
// Optional BHT_PERF_COUNTERS_EN adds saturating branch/mispredict counters.
module branch_history_tracker #(
   parameter int DEPTH     = 4,
   parameter int HIST_BITS = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   branch_history_tracker_if.slave  bus
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [15:0]          pc_mem_r   [DEPTH];
   logic                 pred_mem_r [DEPTH];
   logic [HIST_BITS-1:0] snap_mem_r [DEPTH];
   logic [PTR_W-1:0]     head_r, tail_r;
   logic [CNT_W-1:0]     count_r, count_nxt_s;
   logic [HIST_BITS-1:0] history_r, resolved_history_r;
   logic [15:0]          resolved_pc_r;
   logic                 update_pattern_r, mispredict_r, wb_take_jump_r, underflow_err_r;
   logic                 empty_s, full_s, pop_s, misp_s, push_s;

   // Pop/push qualification; a push into a full FIFO is legal only alongside a correct pop.
   always_comb begin
      empty_s = (count_r == CNT_W'(0));
      full_s  = (count_r == CNT_W'(DEPTH));
      pop_s   = bus.wb_branch & ~empty_s;
      misp_s  = pop_s & (bus.wb_taken != pred_mem_r[head_r]);
      push_s  = bus.fetch_branch & ~bus.flush & ~misp_s & (~full_s | pop_s);
   end

   // Occupancy next-state.
   always_comb begin
      count_nxt_s = count_r;
      if (misp_s | bus.flush) begin
         count_nxt_s = CNT_W'(0);
      end else if (push_s & ~pop_s) begin
         count_nxt_s = count_r + CNT_W'(1);
      end else if (~push_s & pop_s) begin
         count_nxt_s = count_r - CNT_W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // FIFO storage, pointers, history and registered resolution outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_r[i]   <= 16'h0000;
            pred_mem_r[i] <= 1'b0;
            snap_mem_r[i] <= '0;
         end
         head_r             <= '0;
         tail_r             <= '0;
         count_r            <= '0;
         history_r          <= '0;
         resolved_history_r <= '0;
         resolved_pc_r      <= 16'h0000;
         update_pattern_r   <= 1'b0;
         mispredict_r       <= 1'b0;
         wb_take_jump_r     <= 1'b0;
         underflow_err_r    <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         if (push_s) begin
            pc_mem_r[tail_r]   <= bus.fetch_pc;
            pred_mem_r[tail_r] <= bus.fetch_predict_taken;
            snap_mem_r[tail_r] <= history_r;
            tail_r             <= tail_r + PTR_W'(1);
         end
         // Discarding everything in flight collapses the head onto the (unmoved) tail.
         if (misp_s | bus.flush) begin
            head_r <= tail_r;
         end else if (pop_s) begin
            head_r <= head_r + PTR_W'(1);
         end
         if (misp_s) begin
            history_r <= {snap_mem_r[head_r][HIST_BITS-2:0], bus.wb_taken};
         end else if (push_s) begin
            history_r <= {history_r[HIST_BITS-2:0], bus.fetch_predict_taken};
         end
         update_pattern_r <= pop_s;
         mispredict_r     <= misp_s;
         if (pop_s) begin
            resolved_pc_r      <= pc_mem_r[head_r];
            resolved_history_r <= snap_mem_r[head_r];
            wb_take_jump_r     <= bus.wb_taken;
         end
         if (bus.wb_branch & empty_s) begin
            underflow_err_r <= 1'b1;
         end
      end
   end

   assign bus.history          = history_r;
   assign bus.fetch_stall      = full_s;
   assign bus.update_pattern   = update_pattern_r;
   assign bus.resolved_pc      = resolved_pc_r;
   assign bus.resolved_history = resolved_history_r;
   assign bus.wb_take_jump     = wb_take_jump_r;
   assign bus.mispredict       = mispredict_r;
   assign bus.underflow_err    = underflow_err_r;

`ifdef BHT_PERF_COUNTERS_EN
   logic [15:0] branch_cnt_r, misp_cnt_r;

   // Saturating event counters, stepping at the edge that raises each pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_cnt_r <= 16'h0000;
         misp_cnt_r   <= 16'h0000;
      end else begin
         if (pop_s && branch_cnt_r != 16'hFFFF) begin
            branch_cnt_r <= branch_cnt_r + 16'h0001;
         end
         if (misp_s && misp_cnt_r != 16'hFFFF) begin
            misp_cnt_r <= misp_cnt_r + 16'h0001;
         end
      end
   end

   assign bus.branch_count     = branch_cnt_r;
   assign bus.mispredict_count = misp_cnt_r;
`endif
endmodule
